inst_queue: RTL and testbench

Parametrised unified instruction queue between the ICache/BPU fetch stage and the decode (if_id) stage. Accepts up to FETCH_WIDTH fetched instructions per cycle, drops lanes after a predicted-taken branch, compacts survivors into one circular buffer, and issues up to ISSUE_WIDTH instructions per cycle in program order. It replaces the per-lane twin-FIFO buffer and removes lane misalignment when only some lanes are valid.

---
 rtl/pipeline_types.sv | 23 ++
 rtl/iq_compact.sv | 32 +++
 rtl/inst_queue.sv | 143 ++++++++++++++
 tb/tb_inst_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_types.sv
// Shared pipeline types for the fetch-to-decode instruction queue.
// Holds the queue entry layout and the default queue depth.
package pipeline_types;

    localparam int IQ_DEPTH    = 32;
    localparam int EXC_NUM     = 6;
    localparam int EXC_CAUSE_W = 7;

    typedef struct packed {
        logic [31:0]                           pc;
        logic [31:0]                           inst;
        logic [EXC_NUM-1:0]                    is_exception;
        logic [EXC_NUM-1:0][EXC_CAUSE_W-1:0]   exception_cause;
        logic                                  is_branch;
        logic                                  pre_taken;
        logic [31:0]                           pre_branch_addr;
    } iq_entry_t;

    function automatic logic is_taken(input iq_entry_t e);
        return e.is_branch & e.pre_taken;
    endfunction

endpackage

// File: rtl/iq_compact.sv
// Fetch-lane kill after a predicted-taken branch plus prefix-count write offsets.
// Purely combinational; the queue top adds offsets to its tail pointer.
module iq_compact #(
    parameter  int FETCH_WIDTH = 2,
    localparam int CW          = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [FETCH_WIDTH-1:0]         fetch_valid_i,
    input  logic [FETCH_WIDTH-1:0]         lane_taken_i,
    output logic [FETCH_WIDTH-1:0]         keep_o,
    output logic [FETCH_WIDTH-1:0][CW-1:0] offset_o,
    output logic [CW-1:0]                  keep_count_o
);

    logic          takenSeen;
    logic [CW-1:0] running;

    // A taken branch kills every younger lane but survives itself.
    always_comb begin
        takenSeen    = 1'b0;
        running      = '0;
        keep_o       = '0;
        offset_o     = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            offset_o[i] = running;
            keep_o[i]   = fetch_valid_i[i] & ~takenSeen;
            running     = running + CW'(keep_o[i]);
            takenSeen   = takenSeen | lane_taken_i[i];
        end
        keep_count_o = running;
    end

endmodule

// File: rtl/inst_queue.sv
// Unified circular instruction queue between fetch and decode.
// Optional perf counters are built when IQ_PERF_EN is defined.
module inst_queue
    import pipeline_types::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = IQ_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              stall,
    input  logic                              pause,
    input  logic      [FETCH_WIDTH-1:0]       fetch_valid,
    input  iq_entry_t [FETCH_WIDTH-1:0]       fetch_entry,
    output logic                              fetch_ready,
    output logic      [ISSUE_WIDTH-1:0]       out_valid,
    output iq_entry_t [ISSUE_WIDTH-1:0]       out_entry,
    input  logic      [ISSUE_WIDTH-1:0]       issue_ready,
    output logic      [$clog2(DEPTH):0]       occupancy,
    output logic      [31:0]                  perf_full_cycles,
    output logic      [31:0]                  perf_empty_cycles
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int FCW  = $clog2(FETCH_WIDTH + 1);
    localparam int ICW  = $clog2(ISSUE_WIDTH + 1);

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CNTW-1:0] count_q, count_d;
    iq_entry_t       ram_q [DEPTH];

    logic [FETCH_WIDTH-1:0]          laneTaken;
    logic [FETCH_WIDTH-1:0]          keep;
    logic [FETCH_WIDTH-1:0][FCW-1:0] offset;
    logic [FCW-1:0]                  keepCount;
    logic [CNTW-1:0]                 freeSlots;
    logic                            pushFire;
    logic [ICW-1:0]                  popCount;
    logic                            popStop;

    always_comb begin
        laneTaken = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            laneTaken[i] = is_taken(fetch_entry[i]);
        end
    end

    iq_compact #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_compact (
        .fetch_valid_i (fetch_valid),
        .lane_taken_i  (laneTaken),
        .keep_o        (keep),
        .offset_o      (offset),
        .keep_count_o  (keepCount)
    );

    // Readiness uses the pre-pop count so a packet is only ever taken whole.
    assign freeSlots   = CNTW'(DEPTH) - count_q;
    assign fetch_ready = !rst && (freeSlots >= CNTW'(FETCH_WIDTH));
    assign pushFire    = fetch_ready && !stall && !flush && (|keep);
    assign occupancy   = rst ? '0 : count_q;

    always_comb begin
        out_valid = '0;
        out_entry = '0;
        popCount  = '0;
        popStop   = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            out_valid[k] = !rst && !pause && (count_q > CNTW'(k));
            if (out_valid[k]) begin
                out_entry[k] = ram_q[head_q + PW'(k)];
            end
            if (!popStop && out_valid[k] && issue_ready[k]) begin
                popCount = popCount + ICW'(1);
            end else begin
                popStop = 1'b1;
            end
        end
    end

    always_comb begin
        head_d  = head_q + PW'(popCount);
        tail_d  = tail_q + (pushFire ? PW'(keepCount) : '0);
        count_d = count_q + (pushFire ? CNTW'(keepCount) : '0) - CNTW'(popCount);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never reset; out_entry gating hides stale contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (pushFire && keep[i]) begin
                ram_q[tail_q + PW'(offset[i])] <= fetch_entry[i];
            end
        end
    end

`ifdef IQ_PERF_EN
    logic [31:0] perf_full_q;
    logic [31:0] perf_empty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            if (!fetch_ready && (perf_full_q != 32'hFFFF_FFFF)) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
            if ((count_q == '0) && (perf_empty_q != 32'hFFFF_FFFF)) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_empty_cycles = perf_empty_q;
`else
    assign perf_full_cycles  = 32'd0;
    assign perf_empty_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed vector table, then queue-model sequences
// covering full, wrap, reset and flush. Perf expectations follow IQ_PERF_EN.
module tb_inst_queue;
    import pipeline_types::*;

    localparam int FW    = 2;
    localparam int IW    = 2;
    localparam int DEPTH = 32;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic                 stall;
    logic                 pause;
    logic      [FW-1:0]   fetch_valid;
    iq_entry_t [FW-1:0]   fetch_entry;
    logic                 fetch_ready;
    logic      [IW-1:0]   out_valid;
    iq_entry_t [IW-1:0]   out_entry;
    logic      [IW-1:0]   issue_ready;
    logic      [5:0]      occupancy;
    logic      [31:0]     perf_full_cycles;
    logic      [31:0]     perf_empty_cycles;

    int errCount   = 0;
    int checkCount = 0;

    logic [31:0] pcQ [$];
    int          modelFull  = 0;
    int          modelEmpty = 0;
    bit          perfKnown  = 0;

    inst_queue #(
        .FETCH_WIDTH (FW),
        .ISSUE_WIDTH (IW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .stall             (stall),
        .pause             (pause),
        .fetch_valid       (fetch_valid),
        .fetch_entry       (fetch_entry),
        .fetch_ready       (fetch_ready),
        .out_valid         (out_valid),
        .out_entry         (out_entry),
        .issue_ready       (issue_ready),
        .occupancy         (occupancy),
        .perf_full_cycles  (perf_full_cycles),
        .perf_empty_cycles (perf_empty_cycles)
    );

    // Free-running clock; inputs change on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC bit 1 marks a predicted-taken branch; other fields derive from the PC.
    function automatic iq_entry_t makeEntry(input logic [31:0] pc);
        iq_entry_t e;
        e.pc              = pc;
        e.inst            = ~pc;
        e.is_exception    = pc[9:4];
        for (int c = 0; c < 6; c++) begin
            e.exception_cause[c] = pc[6:0] + 7'(c);
        end
        e.is_branch       = pc[1];
        e.pre_taken       = pc[1];
        e.pre_branch_addr = pc + 32'h40;
        return e;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic checkEntry(input string tag, input iq_entry_t act, input iq_entry_t exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge.
    task automatic applyStimulus(input logic r, input logic f, input logic s, input logic p,
                                 input logic [1:0] fv, input logic [31:0] pc0,
                                 input logic [31:0] pc1, input logic [1:0] ir);
        @(negedge clk);
        rst            = r;
        flush          = f;
        stall          = s;
        pause          = p;
        fetch_valid    = fv;
        fetch_entry[0] = makeEntry(pc0);
        fetch_entry[1] = makeEntry(pc1);
        issue_ready    = ir;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic efr, input logic [1:0] eov,
                               input logic [5:0] eocc, input logic [31:0] ep0,
                               input logic [31:0] ep1);
        checkVal({tag, ".fetch_ready"}, 32'(fetch_ready), 32'(efr));
        checkVal({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
        checkVal({tag, ".occupancy"}, 32'(occupancy), 32'(eocc));
        checkEntry({tag, ".entry0"}, out_entry[0], eov[0] ? makeEntry(ep0) : '0);
        checkEntry({tag, ".entry1"}, out_entry[1], eov[1] ? makeEntry(ep1) : '0);
    endtask

    // One cycle against the queue model: predict, compare, then advance the model.
    task automatic modelCycle(input string tag, input logic r, input logic f, input logic s,
                              input logic p, input logic [1:0] fv, input logic [31:0] pc0,
                              input logic [31:0] pc1, input logic [1:0] ir);
        logic        efr;
        logic [1:0]  eov;
        logic [31:0] ep0;
        logic [31:0] ep1;
        int          n;
        bit          stop;
        int          sz;
        sz  = pcQ.size();
        efr = !r && ((DEPTH - sz) >= FW);
        eov = '0;
        for (int k = 0; k < IW; k++) begin
            eov[k] = !r && !p && (k < sz);
        end
        ep0 = (sz > 0) ? pcQ[0] : 32'h0;
        ep1 = (sz > 1) ? pcQ[1] : 32'h0;
        applyStimulus(r, f, s, p, fv, pc0, pc1, ir);
        checkOutput(tag, efr, eov, r ? 6'd0 : 6'(sz), ep0, ep1);
        if (!r) begin
`ifdef IQ_PERF_EN
            if (perfKnown) begin
                checkVal({tag, ".perf_full"}, perf_full_cycles, 32'(modelFull));
                checkVal({tag, ".perf_empty"}, perf_empty_cycles, 32'(modelEmpty));
            end
`else
            checkVal({tag, ".perf_full"}, perf_full_cycles, 32'd0);
            checkVal({tag, ".perf_empty"}, perf_empty_cycles, 32'd0);
`endif
        end
        if (r) begin
            pcQ.delete();
            modelFull  = 0;
            modelEmpty = 0;
            perfKnown  = 1;
        end else begin
            if (!efr) modelFull++;
            if (sz == 0) modelEmpty++;
            if (f) begin
                pcQ.delete();
            end else begin
                n    = 0;
                stop = 0;
                for (int k = 0; k < IW; k++) begin
                    if (!stop && eov[k] && ir[k]) n++;
                    else stop = 1;
                end
                for (int k = 0; k < n; k++) void'(pcQ.pop_front());
                if (efr && !s) begin
                    if (fv[0]) pcQ.push_back(pc0);
                    if (fv[1] && !pc0[1]) pcQ.push_back(pc1);
                end
            end
        end
    endtask

    typedef struct packed {
        logic        r;
        logic        f;
        logic        s;
        logic        p;
        logic [1:0]  fv;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  ir;
        logic        efr;
        logic [1:0]  eov;
        logic [5:0]  eocc;
        logic [31:0] ep0;
        logic [31:0] ep1;
    } vec_t;

    vec_t vecs [0:10];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        stall       = 1'b0;
        pause       = 1'b0;
        fetch_valid = '0;
        fetch_entry = '0;
        issue_ready = '0;

        //          r     f     s     p     fv     pc0           pc1           ir     fr    ov     occ   ep0           ep1
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 32'h1c000000, 32'h1c000004, 2'b11, 1'b0, 2'b00, 6'd0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'h1c000000, 32'h1c000004, 2'b00, 1'b1, 2'b00, 6'd0, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        2'b11, 1'b1, 2'b11, 6'd2, 32'h1c000000, 32'h1c000004};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'h1c000012, 32'h1c000016, 2'b00, 1'b1, 2'b00, 6'd0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h1c00001c, 32'h1c000020, 2'b00, 1'b1, 2'b01, 6'd1, 32'h1c000012, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        2'b10, 1'b1, 2'b11, 6'd2, 32'h1c000012, 32'h1c000020};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        2'b11, 1'b1, 2'b00, 6'd2, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        2'b01, 1'b1, 2'b11, 6'd2, 32'h1c000012, 32'h1c000020};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h1c000030, 32'h1c000034, 2'b00, 1'b1, 2'b01, 6'd1, 32'h1c000020, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        2'b11, 1'b1, 2'b01, 6'd1, 32'h1c000020, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        2'b00, 1'b1, 2'b00, 6'd0, 32'h0,        32'h0};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].r, vecs[i].f, vecs[i].s, vecs[i].p, vecs[i].fv,
                          vecs[i].pc0, vecs[i].pc1, vecs[i].ir);
            checkOutput($sformatf("vec%0d", i), vecs[i].efr, vecs[i].eov, vecs[i].eocc,
                        vecs[i].ep0, vecs[i].ep1);
        end

        // Reset in the middle of a burst must discard everything held.
        for (int i = 0; i < 3; i++) begin
            modelCycle("rstBurst", 0, 0, 0, 0, 2'b11, 32'h1d000000 + 32'(8 * i),
                       32'h1d000004 + 32'(8 * i), 2'b00);
        end
        modelCycle("rstHold", 1, 0, 0, 0, 2'b11, 32'h1d000100, 32'h1d000104, 2'b11);
        modelCycle("postRst", 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11);
        modelCycle("postRst2", 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11);

        // Fill to DEPTH, present an ignored packet, then free space and drain.
        for (int i = 0; i < 16; i++) begin
            modelCycle("fill", 0, 0, 0, 0, 2'b11, 32'h1e000000 + 32'(8 * i),
                       32'h1e000004 + 32'(8 * i), 2'b00);
        end
        modelCycle("full", 0, 0, 0, 0, 2'b11, 32'h1eff0000, 32'h1eff0004, 2'b00);
        modelCycle("fullPop", 0, 0, 0, 0, 2'b11, 32'h1eff0000, 32'h1eff0004, 2'b11);
        modelCycle("afterPop", 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b00);
        for (int i = 0; i < 24 && pcQ.size() > 0; i++) begin
            modelCycle("drainFull", 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11);
        end

        // Odd tail alignment so a two-lane push straddles the end of the buffer.
        modelCycle("wrapOne", 0, 0, 0, 0, 2'b01, 32'h1f000000, 32'h0, 2'b00);
        for (int i = 0; i < 16; i++) begin
            modelCycle("wrap", 0, 0, 0, 0, 2'b11, 32'h1f000100 + 32'(8 * i),
                       32'h1f000104 + 32'(8 * i), 2'b11);
        end
        for (int i = 0; i < 8 && pcQ.size() > 0; i++) begin
            modelCycle("drainWrap", 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11);
        end

        // Flush with a concurrent push and pop at occupancy 5.
        modelCycle("preFlush", 0, 0, 0, 0, 2'b11, 32'h1a000000, 32'h1a000004, 2'b00);
        modelCycle("preFlush", 0, 0, 0, 0, 2'b11, 32'h1a000008, 32'h1a00000c, 2'b00);
        modelCycle("preFlush", 0, 0, 0, 0, 2'b01, 32'h1a000010, 32'h0, 2'b00);
        modelCycle("flush", 0, 1, 0, 0, 2'b11, 32'h1a000020, 32'h1a000024, 2'b11);
        for (int i = 0; i < 3; i++) begin
            modelCycle("postFlush", 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
